// File: rtl/dsc_op_sequencer.sv
// Runs one multiply operation at a time on a DSC core: accepts operands and a
// cycle budget, sequences core reset/enable, and returns result, cycle count and status.
module dsc_op_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned WXIP1      = NUM_INPUTS * DATA_WIDTH + 1
) (
  input  logic                             gclk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [WXIP1-1:0]                 in_budget,
  input  logic                             abort,
  output logic                             core_rst,
  output logic                             core_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_out,
  input  logic                             core_op_finished,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_result,
  output logic [WXIP1-1:0]                 out_cycles,
  output logic                             out_truncated,
  output logic                             out_overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic [WXIP1-1:0] cnt;
  logic [WXIP1-1:0] budget;
  logic [WXIP1-1:0] cnt_inc;
  logic             bud_hit;
  logic             ovf_hit;
  logic             term;

  // Termination conditions seen on the current RUN edge
  assign cnt_inc = cnt + WXIP1'(1);
  assign bud_hit = (budget != '0) && (cnt_inc == budget);
  assign ovf_hit = (cnt_inc == '1);
  assign term    = core_op_finished || bud_hit || abort || ovf_hit;

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      core_rst      <= 1'b1;
      core_en       <= 1'b0;
      core_data     <= '0;
      budget        <= '0;
      cnt           <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_cycles    <= '0;
      out_truncated <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          core_rst <= 1'b1;
          core_en  <= 1'b0;
          if (in_valid && in_ready) begin
            core_data <= in_data;
            budget    <= in_budget;
            cnt       <= '0;
            in_ready  <= 1'b0;
            state     <= LOAD;
          end
        end
        // Core has seen the new operands under reset for one cycle
        LOAD: begin
          core_rst <= 1'b0;
          core_en  <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          cnt <= cnt_inc;
          if (term) begin
            out_result    <= core_data_out;
            out_cycles    <= cnt_inc;
            out_truncated <= !core_op_finished;
            out_overflow  <= !core_op_finished && !bud_hit && !abort && ovf_hit;
            core_en       <= 1'b0;
            out_valid     <= 1'b1;
            state         <= DONE;
          end
        end
        // Core frozen (no reset, no enable) until the result is taken
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            core_rst  <= 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
